// File: rtl/dispatcher_rr.sv
// Round-robin intake of worker results from NUM_CH channels. Each accepted result
// goes to the packet-request FIFO, the worker-result FIFO, the END pulse or the drop counter.

module dispatcher_rr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == DEPTH_C);
  assign valid = (count != '0);
  assign dout  = mem[rd_ptr];
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign wr_en = push & ~full;
  assign rd_en = pop & valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (rd_en && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

module dispatcher_rr #(
  parameter int NUM_CH               = 4,
  parameter int FIFO_DEPTH           = 4,
  parameter int WORKER_RESULT_WIDTH  = 47,
  parameter int PACKET_REQUEST_WIDTH = 79,
  parameter int DROP_CNT_WIDTH       = 8
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  output logic                                  EXECUTION_END,
  output logic [DROP_CNT_WIDTH-1:0]             DROP_COUNT,
  input  logic [NUM_CH-1:0]                     RECEIVE_WR_VALID,
  input  logic [NUM_CH*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic [NUM_CH-1:0]                     RECEIVE_WR_READY,
  output logic                                  SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]        SEND_WR_DATA,
  input  logic                                  SEND_WR_READY,
  output logic                                  SEND_PR_VALID,
  output logic [PACKET_REQUEST_WIDTH-1:0]       SEND_PR_DATA,
  input  logic                                  SEND_PR_READY
);
  localparam int W       = WORKER_RESULT_WIDTH;
  localparam int DATA_W  = 32;
  localparam int COLOR_W = 4;
  localparam int ADDR_W  = W - 3 - COLOR_W - DATA_W;
  localparam int PW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [PW:0]   NCH_C   = (PW+1)'(NUM_CH);
  localparam logic [PW-1:0] LAST_CH = PW'(NUM_CH - 1);

  localparam logic [2:0] OPT_EXEC  = 3'd0;
  localparam logic [2:0] OPT_ONE   = 3'd1;
  localparam logic [2:0] OPT_LEFT  = 3'd2;
  localparam logic [2:0] OPT_RIGHT = 3'd3;
  localparam logic [2:0] OPT_END   = 3'd4;

  typedef enum logic [1:0] {CL_PR, CL_WR, CL_END, CL_DROP} cls_t;

  // Worker-result layout: {dest_option[2:0], dest_addr, color[3:0], data[31:0]}
  function automatic logic [2:0] get_dest_option(input logic [W-1:0] r);
    return r[W-1 -: 3];
  endfunction

  function automatic logic [ADDR_W-1:0] get_dest_addr(input logic [W-1:0] r);
    return r[DATA_W+COLOR_W +: ADDR_W];
  endfunction

  function automatic logic [COLOR_W-1:0] get_color(input logic [W-1:0] r);
    return r[DATA_W +: COLOR_W];
  endfunction

  function automatic logic [DATA_W-1:0] get_data(input logic [W-1:0] r);
    return r[DATA_W-1:0];
  endfunction

  function automatic logic [PACKET_REQUEST_WIDTH-1:0] make_packet_request(
    input logic [2:0]         dest_option,
    input logic [ADDR_W-1:0]  dest_addr,
    input logic [COLOR_W-1:0] color,
    input logic [DATA_W-1:0]  data,
    input logic [31:0]        ext
  );
    return {dest_option, dest_addr, color, data, ext};
  endfunction

  function automatic cls_t classify(input logic [2:0] opt);
    case (opt)
      OPT_EXEC, OPT_ONE:  return CL_PR;
      OPT_LEFT, OPT_RIGHT: return CL_WR;
      OPT_END:            return CL_END;
      default:            return CL_DROP;
    endcase
  endfunction

  logic [W-1:0]      ch_data [NUM_CH];
  cls_t              ch_cls  [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic              pr_full;
  logic              wr_full;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant;
  logic              found;
  logic [PW:0]       idx;
  logic [W-1:0]      sel_data;
  cls_t              sel_cls;
  logic              push_pr;
  logic              push_wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = RECEIVE_WR_DATA[i*W +: W];
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_cls[i] = classify(get_dest_option(ch_data[i]));
      case (ch_cls[i])
        CL_PR:   elig[i] = RECEIVE_WR_VALID[i] & ~pr_full;
        CL_WR:   elig[i] = RECEIVE_WR_VALID[i] & ~wr_full;
        default: elig[i] = RECEIVE_WR_VALID[i];
      endcase
    end
  end

  // First eligible channel at or after ptr, wrapping modulo NUM_CH.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= NCH_C) idx = idx - NCH_C;
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        grant = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    RECEIVE_WR_READY = '0;
    if (found && RST_N) RECEIVE_WR_READY[grant] = 1'b1;
  end

  assign sel_data = ch_data[grant];
  assign sel_cls  = ch_cls[grant];
  assign push_pr  = found && (sel_cls == CL_PR);
  assign push_wr  = found && (sel_cls == CL_WR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr           <= '0;
      EXECUTION_END <= 1'b0;
      DROP_COUNT    <= '0;
    end else begin
      EXECUTION_END <= found && (sel_cls == CL_END);
      if (found) ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
      if (found && (sel_cls == CL_DROP) && (DROP_COUNT != '1)) begin
        DROP_COUNT <= DROP_COUNT + 1'b1;
      end
    end
  end

  dispatcher_rr_fifo #(
    .WIDTH (PACKET_REQUEST_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pr_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push_pr),
    .din   (make_packet_request(get_dest_option(sel_data), get_dest_addr(sel_data),
                                get_color(sel_data), get_data(sel_data), 32'b0)),
    .pop   (SEND_PR_READY),
    .full  (pr_full),
    .valid (SEND_PR_VALID),
    .dout  (SEND_PR_DATA)
  );

  dispatcher_rr_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push_wr),
    .din   (sel_data),
    .pop   (SEND_WR_READY),
    .full  (wr_full),
    .valid (SEND_WR_VALID),
    .dout  (SEND_WR_DATA)
  );
endmodule

// File: tb/tb_dispatcher_rr.sv
// Scoreboard bench for dispatcher_rr: per-channel sources, a round-robin reference,
// and expected-output queues checked at every falling edge.
module tb_dispatcher_rr;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int W     = 47;
  localparam int PRW   = 79;

  typedef logic [W-1:0] res_t;
  typedef logic [PRW-1:0] pr_t;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             EXECUTION_END;
  logic [7:0]       DROP_COUNT;
  logic [NCH-1:0]   RECEIVE_WR_VALID = '0;
  logic [NCH*W-1:0] RECEIVE_WR_DATA = '0;
  logic [NCH-1:0]   RECEIVE_WR_READY;
  logic             SEND_WR_VALID;
  logic [W-1:0]     SEND_WR_DATA;
  logic             SEND_WR_READY = 1'b1;
  logic             SEND_PR_VALID;
  logic [PRW-1:0]   SEND_PR_DATA;
  logic             SEND_PR_READY = 1'b1;

  dispatcher_rr #(
    .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .WORKER_RESULT_WIDTH(W),
    .PACKET_REQUEST_WIDTH(PRW), .DROP_CNT_WIDTH(8)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EXECUTION_END(EXECUTION_END), .DROP_COUNT(DROP_COUNT),
    .RECEIVE_WR_VALID(RECEIVE_WR_VALID), .RECEIVE_WR_DATA(RECEIVE_WR_DATA),
    .RECEIVE_WR_READY(RECEIVE_WR_READY),
    .SEND_WR_VALID(SEND_WR_VALID), .SEND_WR_DATA(SEND_WR_DATA), .SEND_WR_READY(SEND_WR_READY),
    .SEND_PR_VALID(SEND_PR_VALID), .SEND_PR_DATA(SEND_PR_DATA), .SEND_PR_READY(SEND_PR_READY)
  );

  initial forever #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_err = 0;
  res_t src_q [NCH][$];
  res_t wr_q[$];
  pr_t  pr_q[$];
  int   acc_log[$];
  int   m_ptr = 0;
  logic m_end = 1'b0;
  int   m_drop = 0;
  int   end_hi = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cls_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 0;
      3'd2, 3'd3: return 1;
      3'd4:       return 2;
      default:    return 3;
    endcase
  endfunction

  function automatic pr_t make_pr(input res_t r);
    return {r[46:44], r[43:36], r[35:32], r[31:0], 32'h0};
  endfunction

  function automatic res_t mk(input logic [2:0] op);
    res_t r;
    r = {op, 8'($urandom), 4'($urandom), 32'($urandom)};
    return r;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < NCH; i++) begin
      RECEIVE_WR_VALID[i] = (src_q[i].size() > 0);
      RECEIVE_WR_DATA[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    #1 drive_bus();
  end

  // Reference model: round-robin grant, expected FIFO contents, END pulse, drop count.
  always @(negedge CLK) begin : mon
    int g;
    int c;
    int cl;
    logic [NCH-1:0] exp_rdy;
    res_t ch [NCH];
    res_t r;
    if (!RST_N) begin
      chk("rst_ready", RECEIVE_WR_READY, '0);
      chk("rst_wr_valid", SEND_WR_VALID, 1'b0);
      chk("rst_pr_valid", SEND_PR_VALID, 1'b0);
      chk("rst_exec_end", EXECUTION_END, 1'b0);
      chk("rst_drop", DROP_COUNT, 8'd0);
      wr_q.delete();
      pr_q.delete();
      m_ptr = 0;
      m_end = 1'b0;
      m_drop = 0;
    end else begin
      for (int i = 0; i < NCH; i++) ch[i] = RECEIVE_WR_DATA[i*W +: W];
      g = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        cl = cls_of(ch[c][W-1 -: 3]);
        if (g < 0 && RECEIVE_WR_VALID[c] &&
            ((cl == 0 && pr_q.size() < DEPTH) || (cl == 1 && wr_q.size() < DEPTH) || cl >= 2))
          g = c;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("ready", RECEIVE_WR_READY, exp_rdy);
      chk("wr_valid", SEND_WR_VALID, wr_q.size() != 0);
      if (SEND_WR_VALID && wr_q.size() != 0) begin
        chk("wr_data", SEND_WR_DATA, wr_q[0]);
        if (SEND_WR_READY) void'(wr_q.pop_front());
      end
      chk("pr_valid", SEND_PR_VALID, pr_q.size() != 0);
      if (SEND_PR_VALID && pr_q.size() != 0) begin
        chk("pr_data", SEND_PR_DATA, pr_q[0]);
        if (SEND_PR_READY) void'(pr_q.pop_front());
      end
      chk("exec_end", EXECUTION_END, m_end);
      chk("drop_count", DROP_COUNT, m_drop[7:0]);
      if (EXECUTION_END) end_hi++;
      m_end = 1'b0;
      if (g >= 0) begin
        r = ch[g];
        case (cls_of(r[W-1 -: 3]))
          0:       pr_q.push_back(make_pr(r));
          1:       wr_q.push_back(r);
          2:       m_end = 1'b1;
          default: if (m_drop < 255) m_drop++;
        endcase
        m_ptr = (g + 1) % NCH;
        acc_log.push_back(g);
      end
      for (int i = 0; i < NCH; i++)
        if (RECEIVE_WR_READY[i] && RECEIVE_WR_VALID[i] && src_q[i].size() > 0)
          void'(src_q[i].pop_front());
    end
  end

  function automatic logic all_idle();
    logic idle;
    idle = (wr_q.size() == 0) && (pr_q.size() == 0);
    for (int i = 0; i < NCH; i++) if (src_q[i].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !all_idle()) begin
      cycles(1);
      n++;
    end
    cycles(2);
    chk("idle_reached", all_idle(), 1'b1);
  endtask

  task automatic push(input int ch, input res_t r);
    src_q[ch].push_back(r);
    drive_bus();
  endtask

  task automatic do_reset();
    cycles(1);
    RST_N = 1'b0;
    for (int i = 0; i < NCH; i++) src_q[i].delete();
    drive_bus();
    cycles(2);
    RST_N = 1'b1;
  endtask

  initial begin
    res_t r;
    cycles(3);
    RST_N = 1'b1;

    // single LEFT on ch2, then probe pointer = 3
    r = mk(3'd2);
    push(2, r);
    @(negedge CLK); #1;
    chk("t1_ready2", RECEIVE_WR_READY, 4'b0100);
    @(negedge CLK); #1;
    chk("t1_wr_valid", SEND_WR_VALID, 1'b1);
    chk("t1_wr_data", SEND_WR_DATA, r);
    cycles(1);
    acc_log.delete();
    push(0, mk(3'd2));
    push(3, mk(3'd3));
    wait_idle(20);
    chk("t1_ptr3", acc_log[0], 3);

    // all channels holding EXEC results
    do_reset();
    acc_log.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NCH; i++) push(i, mk(3'd0));
    wait_idle(40);
    for (int k = 0; k < 5; k++) chk("t2_order", acc_log[k], k % NCH);

    // WR backpressure: ch0 blocks on a full FIFO while ch1 keeps flowing
    SEND_WR_READY = 1'b0;
    acc_log.delete();
    for (int k = 0; k < 5; k++) push(0, mk(3'(2 + (k % 2))));
    for (int k = 0; k < 6; k++) push(1, mk(3'd0));
    cycles(14);
    @(negedge CLK); #1;
    chk("t3_ch0_blocked", RECEIVE_WR_READY[0], 1'b0);
    chk("t3_ch0_left", src_q[0].size(), 1);
    chk("t3_ch1_done", src_q[1].size(), 0);
    chk("t3_wr_full_valid", SEND_WR_VALID, 1'b1);
    cycles(1);
    SEND_WR_READY = 1'b1;
    wait_idle(40);

    // back-to-back END
    end_hi = 0;
    push(1, mk(3'd4));
    push(3, mk(3'd4));
    cycles(6);
    chk("t4_end_cycles", end_hi, 2);

    // mixed random traffic with random downstream stalls
    for (int i = 0; i < NCH; i++)
      for (int k = 0; k < 30; k++) push(i, mk(3'($urandom_range(0, 7))));
    for (int c = 0; c < 300; c++) begin
      SEND_WR_READY = 1'($urandom);
      SEND_PR_READY = 1'($urandom);
      cycles(1);
    end
    SEND_WR_READY = 1'b1;
    SEND_PR_READY = 1'b1;
    wait_idle(200);

    // drop counter saturation
    do_reset();
    for (int k = 0; k < 300; k++) push(2, mk(3'(5 + (k % 3))));
    wait_idle(400);
    chk("t5_drop_sat", DROP_COUNT, 8'd255);

    // reset with both FIFOs holding two entries
    do_reset();
    SEND_WR_READY = 1'b0;
    SEND_PR_READY = 1'b0;
    push(0, mk(3'd2)); push(0, mk(3'd3));
    push(1, mk(3'd1)); push(1, mk(3'd0));
    cycles(6);
    chk("t6_wr_held", SEND_WR_VALID, 1'b1);
    chk("t6_pr_held", SEND_PR_VALID, 1'b1);
    RST_N = 1'b0;
    for (int i = 0; i < NCH; i++) src_q[i].delete();
    drive_bus();
    #1;
    chk("t6_wr_drop", SEND_WR_VALID, 1'b0);
    chk("t6_pr_drop", SEND_PR_VALID, 1'b0);
    cycles(2);
    RST_N = 1'b1;
    SEND_WR_READY = 1'b1;
    SEND_PR_READY = 1'b1;
    cycles(3);
    acc_log.delete();
    push(1, mk(3'd2));
    push(3, mk(3'd2));
    wait_idle(20);
    chk("t6_ptr0", acc_log[0], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
